w_schedule_reader: RTL

// - Consumer side of the SHA-256 message-schedule path. Accepts one 512-bit padded block,

---
 rtl/sha256_pkg.sv | 30 +++
 rtl/w_expand.sv | 16 +
 rtl/w_schedule_reader.sv | 90 +++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 shared types and schedule helpers.
// Word width, FSM encoding and the small sigma functions.
package sha256_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_e;

  function automatic word_t rotr(
    input word_t       x,
    input int unsigned n
  );
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/w_expand.sv
// Next schedule word from the sliding window taps.
// W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
module w_expand
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w0_i,
  input  logic [WORD_W-1:0] w1_i,
  input  logic [WORD_W-1:0] w9_i,
  input  logic [WORD_W-1:0] w14_i,
  output logic [WORD_W-1:0] wn_o
);

  assign wn_o = sigma1(w14_i) + w9_i
              + sigma0(w1_i) + w0_i;

endmodule

// File: rtl/w_schedule_reader.sv
// Streams SHA-256 schedule words W[0..W_LENGTH-1] from one block
// using a 16-word window that expands W[16..] on the fly.
module w_schedule_reader
  import sha256_pkg::*;
#(
  parameter int W_LENGTH = 64,
  parameter int IDX_W    = $clog2(W_LENGTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              block_valid,
  output logic              block_ready,
  input  logic [511:0]      message_vector,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_word,
  output logic [IDX_W-1:0]  w_index,
  output logic              w_last,
  output logic              schedule_complete
);

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(W_LENGTH - 1);

  state_e           state_q;
  word_t            win_q [16];
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic             clr;
  logic             hs;
  word_t            wn;

  assign clr = !reset || !enable;
  assign hs  = valid_q && w_ready;

  w_expand u_expand (
    .w0_i  (win_q[0]),
    .w1_i  (win_q[1]),
    .w9_i  (win_q[9]),
    .w14_i (win_q[14]),
    .wn_o  (wn)
  );

  always_ff @(posedge clock) begin
    if (clr) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < 16; i++)
        win_q[i] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (block_valid) begin
            for (int i = 0; i < 16; i++)
              win_q[i] <= message_vector[511-32*i -: 32];
            idx_q   <= '0;
            valid_q <= 1'b1;
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (hs) begin
            for (int i = 0; i < 15; i++)
              win_q[i] <= win_q[i+1];
            win_q[15] <= wn;
            // index holds at the last word instead of wrapping
            if (idx_q == LAST) begin
              valid_q <= 1'b0;
              state_q <= S_DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign w_valid           = valid_q;
  assign w_word            = win_q[0];
  assign w_index           = idx_q;
  assign w_last            = valid_q && (idx_q == LAST);
  assign schedule_complete = (state_q == S_DONE);
  assign block_ready       = (state_q == S_IDLE) && !clr;

endmodule
